// File: rtl/chan_fifo_bank_pkg.sv
// Shared definitions for the channel FIFO bank: address-map offsets,
// FIFO count width and legal parameter ranges.
package chan_fifo_bank_pkg;

  localparam int DATA_W   = 8;
  localparam int DATA_OFS = 0;

  // Depth readback channels start right after the data channels.
  function automatic int depthOfs(input int nChan);
    return nChan;
  endfunction

  // Control channel follows the two depth channels of every pair.
  function automatic int ctrlOfs(input int nChan);
    return 3 * nChan;
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int countWidth(input int depthLog2);
    return depthLog2 + 1;
  endfunction

  function automatic bit paramsOk(input int nChan, input int depthLog2, input int baseChan);
    return (nChan >= 1) && (nChan <= 4) &&
           (depthLog2 >= 2) && (depthLog2 <= 7) &&
           (baseChan >= 0) && (baseChan + 3 * nChan <= 127);
  endfunction

endpackage

// File: rtl/chan_fifo_bank_fifo_core.sv
// First-word-fall-through FIFO, 8-bit data, with a synchronous flush that
// overrides any push or pop in the same cycle.
module fifo_core
  import chan_fifo_bank_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic                                flush_in,
  input  logic [DATA_W-1:0]                   pushData_in,
  input  logic                                pushValid_in,
  output logic                                pushReady_out,
  output logic [DATA_W-1:0]                   popData_out,
  output logic                                popValid_out,
  input  logic                                popReady_in,
  output logic [countWidth(DEPTH_LOG2)-1:0]   depth_out
);

  localparam int CW    = countWidth(DEPTH_LOG2);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptrT;
  typedef logic [CW-1:0]         countT;

  localparam countT DEPTH_C = countT'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  ptrT               wrPtr;
  ptrT               rdPtr;
  countT             count;
  logic              doPush;
  logic              doPop;

  // Ready depends only on occupancy, so a full FIFO refuses a push even
  // when it is being popped in the same cycle.
  assign pushReady_out = (count < DEPTH_C);
  assign popValid_out  = (count != '0);
  assign popData_out   = mem[rdPtr];
  assign depth_out     = count;

  assign doPush = pushValid_in && pushReady_out && !flush_in;
  assign doPop  = popReady_in && popValid_out && !flush_in;

  // Pointer and occupancy update; reset and flush both return to empty.
  always_ff @(posedge clk_in) begin
    // NOTE: state registers use <= so every block sees pre-edge values.
    if (reset_in || flush_in) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ptrT'(1);
      if (doPop)  rdPtr <= rdPtr + ptrT'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + countT'(1);
        2'b01:   count <= count - countT'(1);
        default: ;
      endcase
    end
  end

  // Storage write on an accepted push.
  always_ff @(posedge clk_in) begin
    // NOTE: storage has no reset; contents are don't-care until written.
    if (doPush) mem[wrPtr] <= pushData_in;
  end

endmodule

// File: rtl/chan_fifo_bank.sv
// Bank of NCHAN host-visible FIFO channel pairs with depth readback,
// a non-empty bitmap and per-channel flush on the control channel.
module chan_fifo_bank
  import chan_fifo_bank_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int BASE_CHAN  = 0
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [6:0]          chanAddr_in,
  input  logic [7:0]          h2fData_in,
  input  logic                h2fValid_in,
  output logic                h2fReady_out,
  output logic [7:0]          f2hData_out,
  output logic                f2hValid_out,
  input  logic                f2hReady_in,
  output logic [8*NCHAN-1:0]  wrData_out,
  output logic [NCHAN-1:0]    wrValid_out,
  input  logic [NCHAN-1:0]    wrReady_in,
  input  logic [8*NCHAN-1:0]  rdData_in,
  input  logic [NCHAN-1:0]    rdValid_in,
  output logic [NCHAN-1:0]    rdReady_out,
  output logic [8*NCHAN-1:0]  wrDepth_out,
  output logic [8*NCHAN-1:0]  rdDepth_out
);

  localparam int CW        = countWidth(DEPTH_LOG2);
  localparam int DEPTH_OFS = depthOfs(NCHAN);
  localparam int CTRL_OFS  = ctrlOfs(NCHAN);

  if (!paramsOk(NCHAN, DEPTH_LOG2, BASE_CHAN)) begin : gBadParams
    $error("chan_fifo_bank: NCHAN, DEPTH_LOG2 or BASE_CHAN out of range");
  end

  logic [6:0]       ofs;
  logic [NCHAN-1:0] wrPush;
  logic [NCHAN-1:0] wrPushReady;
  logic [NCHAN-1:0] rdPop;
  logic [NCHAN-1:0] rdPopValid;
  logic [NCHAN-1:0] flushVec;
  logic [7:0]       rdHead  [NCHAN];
  logic [CW-1:0]    wrDepth [NCHAN];
  logic [CW-1:0]    rdDepth [NCHAN];

  // Addresses below BASE_CHAN wrap to large offsets and decode as unmapped.
  assign ofs = chanAddr_in - 7'(BASE_CHAN);

  // Host-pipe decode: steer strobes to the addressed FIFO and mux read data.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    h2fReady_out = 1'b1;
    f2hValid_out = 1'b1;
    f2hData_out  = '0;
    wrPush       = '0;
    rdPop        = '0;
    flushVec     = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (ofs == 7'(DATA_OFS + i)) begin
        h2fReady_out = wrPushReady[i];
        wrPush[i]    = h2fValid_in;
        f2hValid_out = rdPopValid[i];
        f2hData_out  = rdHead[i];
        rdPop[i]     = f2hReady_in;
      end
      if (ofs == 7'(DEPTH_OFS + 2 * i))     f2hData_out = 8'(wrDepth[i]);
      if (ofs == 7'(DEPTH_OFS + 2 * i + 1)) f2hData_out = 8'(rdDepth[i]);
    end
    if (ofs == 7'(CTRL_OFS)) begin
      f2hData_out = {4'(rdPopValid), 4'(wrValid_out)};
      if (h2fValid_in) flushVec = h2fData_in[NCHAN-1:0];
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : gChan
    fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) uWrFifo (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .flush_in      (flushVec[i]),
      .pushData_in   (h2fData_in),
      .pushValid_in  (wrPush[i]),
      .pushReady_out (wrPushReady[i]),
      .popData_out   (wrData_out[8*i +: 8]),
      .popValid_out  (wrValid_out[i]),
      .popReady_in   (wrReady_in[i]),
      .depth_out     (wrDepth[i])
    );

    fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) uRdFifo (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .flush_in      (flushVec[i]),
      .pushData_in   (rdData_in[8*i +: 8]),
      .pushValid_in  (rdValid_in[i]),
      .pushReady_out (rdReady_out[i]),
      .popData_out   (rdHead[i]),
      .popValid_out  (rdPopValid[i]),
      .popReady_in   (rdPop[i]),
      .depth_out     (rdDepth[i])
    );

    assign wrDepth_out[8*i +: 8] = 8'(wrDepth[i]);
    assign rdDepth_out[8*i +: 8] = 8'(rdDepth[i]);
  end

endmodule

// File: tb/tb_chan_fifo_bank.sv
// Self-checking bench for chan_fifo_bank: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_chan_fifo_bank;

  localparam int NCHAN      = 2;
  localparam int DEPTH_LOG2 = 2;
  localparam int BASE_CHAN  = 'h10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk_in = 1'b0;
  logic                reset_in;
  logic [6:0]          chanAddr_in;
  logic [7:0]          h2fData_in;
  logic                h2fValid_in;
  logic                h2fReady_out;
  logic [7:0]          f2hData_out;
  logic                f2hValid_out;
  logic                f2hReady_in;
  logic [8*NCHAN-1:0]  wrData_out;
  logic [NCHAN-1:0]    wrValid_out;
  logic [NCHAN-1:0]    wrReady_in;
  logic [8*NCHAN-1:0]  rdData_in;
  logic [NCHAN-1:0]    rdValid_in;
  logic [NCHAN-1:0]    rdReady_out;
  logic [8*NCHAN-1:0]  wrDepth_out;
  logic [8*NCHAN-1:0]  rdDepth_out;

  chan_fifo_bank #(.NCHAN(NCHAN), .DEPTH_LOG2(DEPTH_LOG2), .BASE_CHAN(BASE_CHAN)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .chanAddr_in  (chanAddr_in),
    .h2fData_in   (h2fData_in),
    .h2fValid_in  (h2fValid_in),
    .h2fReady_out (h2fReady_out),
    .f2hData_out  (f2hData_out),
    .f2hValid_out (f2hValid_out),
    .f2hReady_in  (f2hReady_in),
    .wrData_out   (wrData_out),
    .wrValid_out  (wrValid_out),
    .wrReady_in   (wrReady_in),
    .rdData_in    (rdData_in),
    .rdValid_in   (rdValid_in),
    .rdReady_out  (rdReady_out),
    .wrDepth_out  (wrDepth_out),
    .rdDepth_out  (rdDepth_out)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  logic checkEn = 1'b0;

  // Reference model: one queue per FIFO, head at index 0.
  logic [7:0] wrQ [NCHAN][$];
  logic [7:0] rdQ [NCHAN][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hostOfs();
    return int'(chanAddr_in) - BASE_CHAN;
  endfunction

  // Model update at each rising edge from the inputs held across it.
  always @(posedge clk_in) begin
    int o;
    logic [NCHAN-1:0] fl;
    logic doPush, doPop;
    o = hostOfs();
    if (reset_in) begin
      for (int i = 0; i < NCHAN; i++) begin
        wrQ[i].delete();
        rdQ[i].delete();
      end
    end else begin
      fl = (o == 3 * NCHAN && h2fValid_in) ? h2fData_in[NCHAN-1:0] : '0;
      for (int i = 0; i < NCHAN; i++) begin
        if (fl[i]) begin
          wrQ[i].delete();
          rdQ[i].delete();
        end else begin
          doPush = (o == i) && h2fValid_in && (wrQ[i].size() < DEPTH);
          doPop  = wrReady_in[i] && (wrQ[i].size() > 0);
          if (doPop)  void'(wrQ[i].pop_front());
          if (doPush) wrQ[i].push_back(h2fData_in);
          doPush = rdValid_in[i] && (rdQ[i].size() < DEPTH);
          doPop  = (o == i) && f2hReady_in && (rdQ[i].size() > 0);
          if (doPop)  void'(rdQ[i].pop_front());
          if (doPush) rdQ[i].push_back(rdData_in[8*i +: 8]);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    int o;
    logic expR, expV;
    logic [7:0] expD;
    logic [3:0] wrNe, rdNe;
    if (checkEn) begin
      wrNe = '0;
      rdNe = '0;
      for (int i = 0; i < NCHAN; i++) begin
        wrNe[i] = wrQ[i].size() > 0;
        rdNe[i] = rdQ[i].size() > 0;
        check($sformatf("model wrValid[%0d]", i), 64'(wrValid_out[i]), 64'(wrNe[i]));
        if (wrNe[i]) check($sformatf("model wrData[%0d]", i), 64'(wrData_out[8*i +: 8]), 64'(wrQ[i][0]));
        check($sformatf("model rdReady[%0d]", i), 64'(rdReady_out[i]), 64'(rdQ[i].size() < DEPTH));
        check($sformatf("model wrDepth[%0d]", i), 64'(wrDepth_out[8*i +: 8]), 64'(wrQ[i].size()));
        check($sformatf("model rdDepth[%0d]", i), 64'(rdDepth_out[8*i +: 8]), 64'(rdQ[i].size()));
      end
      o = hostOfs();
      expR = 1'b1;
      expV = 1'b1;
      expD = 8'h00;
      if (o >= 0 && o < NCHAN) begin
        expR = wrQ[o].size() < DEPTH;
        expV = rdQ[o].size() > 0;
        if (expV) expD = rdQ[o][0];
      end else if (o >= NCHAN && o < 3 * NCHAN) begin
        if ((o - NCHAN) % 2 == 0) expD = 8'(wrQ[(o - NCHAN) / 2].size());
        else                      expD = 8'(rdQ[(o - NCHAN) / 2].size());
      end else if (o == 3 * NCHAN) begin
        expD = {rdNe, wrNe};
      end
      check("model h2fReady", 64'(h2fReady_out), 64'(expR));
      check("model f2hValid", 64'(f2hValid_out), 64'(expV));
      if (expV) check("model f2hData", 64'(f2hData_out), 64'(expD));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [7:0] wrBytes [5];

  initial begin
    wrBytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    reset_in    = 1'b1;
    chanAddr_in = 7'h10;
    h2fData_in  = '0;
    h2fValid_in = 1'b0;
    f2hReady_in = 1'b0;
    wrReady_in  = '0;
    rdData_in   = '0;
    rdValid_in  = '0;
    tick();
    checkEn = 1'b1;
    tick();

    // Reset state, data channel 0 addressed.
    settle();
    check("reset wrDepth", 64'(wrDepth_out), 64'h0);
    check("reset rdDepth", 64'(rdDepth_out), 64'h0);
    check("reset wrValid", 64'(wrValid_out), 64'b00);
    check("reset rdReady", 64'(rdReady_out), 64'b11);
    check("reset f2hValid", 64'(f2hValid_out), 64'h0);
    check("reset h2fReady", 64'(h2fReady_out), 64'h1);
    reset_in = 1'b0;
    tick();

    // Fill write FIFO 0; the fifth byte must stall.
    for (int k = 0; k < 5; k++) begin
      chanAddr_in = 7'h10;
      h2fData_in  = wrBytes[k];
      h2fValid_in = 1'b1;
      settle();
      check($sformatf("fill h2fReady byte %0d", k), 64'(h2fReady_out), (k < 4) ? 64'h1 : 64'h0);
      tick();
    end
    h2fValid_in = 1'b0;
    chanAddr_in = 7'h12;
    settle();
    check("wr0 depth full", 64'(f2hData_out), 64'h04);
    check("wr0 depth valid", 64'(f2hValid_out), 64'h1);
    tick();

    // Drain while the host retries 0xA5; it lands one cycle after the first pop.
    chanAddr_in = 7'h10;
    h2fData_in  = 8'hA5;
    h2fValid_in = 1'b1;
    wrReady_in  = 2'b01;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("drain wrData %0d", k), 64'(wrData_out[7:0]), 64'(wrBytes[k]));
      check($sformatf("drain wrValid %0d", k), 64'(wrValid_out[0]), 64'h1);
      if (k == 0) check("full pop refuses push", 64'(h2fReady_out), 64'h0);
      if (k == 1) check("slot free next cycle", 64'(h2fReady_out), 64'h1);
      tick();
      if (k == 1) h2fValid_in = 1'b0;
    end
    settle();
    check("drain empty", 64'(wrValid_out), 64'b00);
    wrReady_in = '0;
    tick();

    // Producer streams 0..3 into read FIFO 1 while host reads every cycle.
    for (int j = 0; j < 6; j++) begin
      chanAddr_in = 7'h11;
      f2hReady_in = 1'b1;
      rdValid_in  = (j < 4) ? 2'b10 : 2'b00;
      rdData_in   = {8'(j), 8'h00};
      settle();
      if (j >= 1 && j <= 4) begin
        check($sformatf("stream f2hValid %0d", j), 64'(f2hValid_out), 64'h1);
        check($sformatf("stream f2hData %0d", j), 64'(f2hData_out), 64'(j - 1));
      end else begin
        check($sformatf("stream empty %0d", j), 64'(f2hValid_out), 64'h0);
      end
      tick();
    end
    f2hReady_in = 1'b0;
    rdValid_in  = '0;
    chanAddr_in = 7'h15;
    settle();
    check("rd1 depth after stream", 64'(f2hData_out), 64'h00);
    tick();

    // Fill read FIFO 0, then pop and push together while full.
    chanAddr_in = 7'h13;
    for (int k = 0; k < 4; k++) begin
      rdValid_in = 2'b01;
      rdData_in  = {8'h00, 8'(8'h30 + k)};
      tick();
    end
    settle();
    check("rd0 depth full", 64'(f2hData_out), 64'h04);
    check("rd0 ready full", 64'(rdReady_out[0]), 64'h0);
    chanAddr_in = 7'h10;
    f2hReady_in = 1'b1;
    rdData_in   = {8'h00, 8'h34};
    settle();
    check("rd0 head", 64'(f2hData_out), 64'h30);
    tick();
    f2hReady_in = 1'b0;
    chanAddr_in = 7'h13;
    settle();
    check("rd0 depth 4->3", 64'(f2hData_out), 64'h03);
    check("rd0 ready after pop", 64'(rdReady_out[0]), 64'h1);
    tick();
    rdValid_in = '0;
    settle();
    check("rd0 depth 3->4", 64'(f2hData_out), 64'h04);
    tick();

    // Load both channels, then flush channel 1 while pushing/popping it.
    h2fValid_in = 1'b1;
    chanAddr_in = 7'h10; h2fData_in = 8'hB0; tick();
    chanAddr_in = 7'h11; h2fData_in = 8'hC0; tick();
    h2fData_in  = 8'hC1; tick();
    h2fValid_in = 1'b0;
    rdValid_in  = 2'b10;
    rdData_in   = {8'hD0, 8'h00};
    tick();
    rdValid_in  = '0;
    chanAddr_in = 7'h16;
    settle();
    check("bitmap before flush", 64'(f2hData_out), 64'h33);
    check("wrDepth before flush", 64'(wrDepth_out), 64'h0201);
    check("rdDepth before flush", 64'(rdDepth_out), 64'h0104);
    tick();
    h2fValid_in = 1'b1;
    h2fData_in  = 8'h02;
    rdValid_in  = 2'b10;
    rdData_in   = {8'hD1, 8'h00};
    wrReady_in  = 2'b10;
    tick();
    h2fValid_in = 1'b0;
    rdValid_in  = '0;
    wrReady_in  = '0;
    settle();
    check("bitmap after flush", 64'(f2hData_out), 64'h11);
    check("wrValid after flush", 64'(wrValid_out), 64'b01);
    check("wrDepth after flush", 64'(wrDepth_out), 64'h0001);
    check("rdDepth after flush", 64'(rdDepth_out), 64'h0004);
    tick();

    // Unmapped and depth-channel writes are discarded.
    chanAddr_in = 7'h17;
    h2fValid_in = 1'b1;
    h2fData_in  = 8'hFF;
    settle();
    check("unmapped data", 64'(f2hData_out), 64'h00);
    check("unmapped valid", 64'(f2hValid_out), 64'h1);
    tick();
    chanAddr_in = 7'h12;
    h2fData_in  = 8'h55;
    tick();
    h2fValid_in = 1'b0;
    chanAddr_in = 7'h0F;
    settle();
    check("below base data", 64'(f2hData_out), 64'h00);
    tick();
    chanAddr_in = 7'h12;
    settle();
    check("wr0 depth unchanged", 64'(f2hData_out), 64'h01);
    tick();

    // Reset mid-stream with three entries queued.
    chanAddr_in = 7'h10;
    h2fValid_in = 1'b1;
    h2fData_in  = 8'hB1; tick();
    h2fData_in  = 8'hB2; tick();
    h2fValid_in = 1'b0;
    settle();
    check("wr0 depth before reset", 64'(wrDepth_out[7:0]), 64'h03);
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    settle();
    check("post-reset wrDepth", 64'(wrDepth_out), 64'h0);
    check("post-reset rdDepth", 64'(rdDepth_out), 64'h0);
    check("post-reset wrValid", 64'(wrValid_out), 64'b00);
    check("post-reset f2hValid", 64'(f2hValid_out), 64'h0);
    tick();
    h2fValid_in = 1'b1;
    h2fData_in  = 8'hE7;
    tick();
    h2fValid_in = 1'b0;
    settle();
    check("first push after reset", 64'(wrData_out[7:0]), 64'hE7);
    check("depth after reset push", 64'(wrDepth_out[7:0]), 64'h01);
    tick();
    tick();

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
